decoder_scan: RTL and testbench
===============================

DECODER_SCAN -- requirements
Module: decoder_scan

Interface
REQ-001 Parameter N, default 2: address width; output count is 2**N; legal range 1..6.
REQ-002 Parameter DWELL, default 1: cycles each output is held in scan mode; legal range 1..255.
REQ-003 Parameter ACTIVE_LOW, default 0: 1 inverts every bit of D (selected line low, others high).
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 en  in  1  block enable; 0 forces idle.
REQ-007 mode  in  1  0 = direct decode, 1 = auto-scan.
REQ-008 load  in  1  in scan mode: reload scan index from A.
REQ-009 A  in  N  address input.
REQ-010 D  out  2**N  registered one-hot (or one-cold) decoded lines.
REQ-011 valid  out  1  D currently carries a selected line.
REQ-012 idx  out  N  index of the currently selected line.
REQ-013 wrap  out  1  one-cycle pulse when scan index rolls from 2**N-1 to 0.

Function
REQ-014 States: IDLE, DIRECT, SCAN; state, D, valid, idx, wrap and the dwell counter are registers; no combinational path from any input to any output.
REQ-015 Next state: en=0 -> IDLE; en=1 and mode=0 -> DIRECT; en=1 and mode=1 -> SCAN.
REQ-016 Priority per cycle: rst > en=0 > mode > load > dwell step.
REQ-017 IDLE: D = inactive level (all 0, or all 1 if ACTIVE_LOW); valid=0; wrap=0; idx holds its last value; dwell counter = 0.
REQ-018 DIRECT: one cycle after a rising edge that samples en=1, mode=0, D has only bit A active, idx=A, valid=1; latency exactly 1 cycle; A may change every cycle; load ignored; wrap=0.
REQ-019 SCAN entry (previous state IDLE or DIRECT): idx=A, dwell counter=0, valid=1, D selects bit A on the next cycle; wrap=0.
REQ-020 SCAN steady: dwell counter increments each cycle; when it reaches DWELL-1 it clears and idx increments by 1 modulo 2**N on the same edge.
REQ-021 Wrap-around: the increment from 2**N-1 to 0 sets wrap=1 for exactly the cycle in which idx=0 is first presented; wrap=0 in all other cycles.
REQ-022 load=1 in SCAN: idx=A, dwell counter=0, wrap=0 on the next cycle, even if a dwell step or wrap was due on that edge.
REQ-023 D always equals the decode of idx when valid=1 (exactly one active bit) and the inactive level when valid=0.
REQ-024 mode switching 1->0 mid-scan: next cycle is DIRECT decode of A; dwell counter clears. Switching 0->1 follows REQ-019.
REQ-025 DWELL=1: idx advances every cycle; N=1: idx toggles 0,1,0 with wrap on each return to 0.
REQ-026 Width: dwell counter is ceil(log2(DWELL+1)) bits; idx arithmetic is N bits with natural rollover.

Reset
REQ-027 When rst=1 at a rising edge: state=IDLE, idx=0, dwell counter=0, valid=0, wrap=0, D=inactive level; this overrides all other inputs.
REQ-028 Reset mid-scan aborts the scan; after rst deasserts with en=1, mode=1, scan restarts from A per REQ-019.

Structure
REQ-029 Shared package decoder_pkg holds the state enumeration (IDLE, DIRECT, SCAN) and the mode encoding constants (MODE_DIRECT=0, MODE_SCAN=1).
REQ-030 A single sub-module decoder_nto2n (parameter N, purely combinational, A -> one-hot 2**N) is instantiated; its output is polarity-adjusted and registered in decoder_scan.

Verification
REQ-031 N=2: rst 2 cycles, then en=1, mode=0, A=2 -> next cycle D=4'b0100, valid=1, idx=2; A=0 next -> D=4'b0001.
REQ-032 N=2, DWELL=1: en=1, mode=1, A=1 -> idx sequence 1,2,3,0,1; D 0010,0100,1000,0001,0010; wrap=1 only at idx=0.
REQ-033 N=3, DWELL=3: scan from A=6 -> idx=6 for 3 cycles, 7 for 3 cycles, then 0 with single wrap pulse.
REQ-034 N=2, DWELL=1: scan at idx=3, load=1, A=1 on the wrap edge -> next idx=1, wrap=0.
REQ-035 N=2, ACTIVE_LOW=1: en=0 -> D=4'b1111, valid=0; direct A=3 -> D=4'b0111.
REQ-036 Mid-scan rst=1 for 1 cycle -> D inactive, valid=0, idx=0; then en=0 for 2 cycles -> outputs stay idle and idx holds 0.

Source files
------------

// File: rtl/decoder_pkg.sv
// Shared types and constants for the scanning N-to-2**N decoder.
package decoder_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } state_e;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage : decoder_pkg

// File: rtl/decoder_scan_if.sv
// Control/address inputs and decoded outputs of decoder_scan.
interface decoder_scan_if #(
  parameter int unsigned N = 2
);
  localparam int unsigned W = 1 << N;

  logic         en;
  logic         mode;
  logic         load;
  logic [N-1:0] A;
  logic [W-1:0] D;
  logic         valid;
  logic [N-1:0] idx;
  logic         wrap;

  modport master (output en, mode, load, A, input D, valid, idx, wrap);
  modport slave  (input en, mode, load, A, output D, valid, idx, wrap);

endinterface : decoder_scan_if

// File: rtl/decoder_nto2n.sv
// Purely combinational N-bit address to 2**N one-hot decoder.
module decoder_nto2n #(
  parameter int unsigned N = 2
) (
  input  logic [N-1:0]        a,
  output logic [(1<<N)-1:0]   y
);

  always_comb begin
    y    = '0;
    y[a] = 1'b1;
  end

endmodule : decoder_nto2n

// File: rtl/decoder_scan.sv
// Registered N-to-2**N decoder with direct and dwell-timed auto-scan modes.
module decoder_scan
  import decoder_pkg::*;
#(
  parameter int unsigned N          = 2,
  parameter int unsigned DWELL      = 1,
  parameter bit          ACTIVE_LOW = 1'b0
) (
  input  logic           clk,
  input  logic           rst,
  decoder_scan_if.slave  bus
);

  localparam int unsigned W  = 1 << N;
  localparam int unsigned CW = $clog2(DWELL + 1);

  localparam logic [N-1:0]  IDX_MAX    = '1;
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
  localparam logic [W-1:0]  INACTIVE   = {W{ACTIVE_LOW}};

  state_e         state_q, state_d;
  logic [N-1:0]   idx_q, idx_d;
  logic [CW-1:0]  dwell_q, dwell_d;
  logic           valid_q, valid_d;
  logic           wrap_q, wrap_d;
  logic [W-1:0]   d_q, d_d;
  logic [W-1:0]   onehot_c;

  // Decode the next index so D lines up with idx in the same cycle.
  decoder_nto2n #(.N(N)) u_dec (
    .a (idx_d),
    .y (onehot_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      dwell_q <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
      d_q     <= INACTIVE;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      dwell_q <= dwell_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
      d_q     <= d_d;
    end
  end

  // Priority: en=0 > mode > load/entry > dwell step.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    dwell_d = dwell_q;
    valid_d = 1'b0;
    wrap_d  = 1'b0;

    if (!bus.en) begin
      state_d = IDLE;
      dwell_d = '0;
    end else if (bus.mode == MODE_DIRECT) begin
      state_d = DIRECT;
      idx_d   = bus.A;
      dwell_d = '0;
      valid_d = 1'b1;
    end else begin
      state_d = SCAN;
      valid_d = 1'b1;
      if (state_q != SCAN || bus.load) begin
        idx_d   = bus.A;
        dwell_d = '0;
      end else if (dwell_q == DWELL_LAST) begin
        dwell_d = '0;
        idx_d   = idx_q + N'(1);
        wrap_d  = (idx_q == IDX_MAX);
      end else begin
        dwell_d = dwell_q + CW'(1);
      end
    end

    d_d = INACTIVE ^ (valid_d ? onehot_c : '0);
  end

  assign bus.D     = d_q;
  assign bus.valid = valid_q;
  assign bus.idx   = idx_q;
  assign bus.wrap  = wrap_q;

endmodule : decoder_scan

// File: tb/tb_decoder_scan.sv
// Directed self-checking bench for decoder_scan in three parameterisations.
module tb_decoder_scan;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  decoder_scan_if #(.N(2)) b2 ();
  decoder_scan_if #(.N(3)) b3 ();
  decoder_scan_if #(.N(2)) bl ();

  decoder_scan #(.N(2), .DWELL(1), .ACTIVE_LOW(1'b0)) u_n2 (.clk(clk), .rst(rst), .bus(b2));
  decoder_scan #(.N(3), .DWELL(3), .ACTIVE_LOW(1'b0)) u_n3 (.clk(clk), .rst(rst), .bus(b3));
  decoder_scan #(.N(2), .DWELL(1), .ACTIVE_LOW(1'b1)) u_al (.clk(clk), .rst(rst), .bus(bl));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    b2.en = 1'b0; b2.mode = 1'b0; b2.load = 1'b0; b2.A = '0;
    b3.en = 1'b0; b3.mode = 1'b0; b3.load = 1'b0; b3.A = '0;
    bl.en = 1'b0; bl.mode = 1'b0; bl.load = 1'b0; bl.A = '0;
    step();
    step();
    checks++;
    if ({b2.D, b2.valid, b2.idx, b2.wrap} !== 8'b0000_0_00_0) begin
      errors++;
      $display("FAIL reset_n2: D=%b valid=%b idx=%0d wrap=%b, required all zero",
               b2.D, b2.valid, b2.idx, b2.wrap);
    end
    checks++;
    if (b3.D !== 8'h00 || b3.valid !== 1'b0 || b3.idx !== 3'd0) begin
      errors++;
      $display("FAIL reset_n3: D=%b valid=%b idx=%0d, required 0/0/0", b3.D, b3.valid, b3.idx);
    end
    checks++;
    if (bl.D !== 4'b1111 || bl.valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_active_low: D=%b valid=%b, required 1111/0", bl.D, bl.valid);
    end
    rst = 1'b0;
  endtask

  task automatic test_direct();
    b2.en = 1'b1; b2.mode = 1'b0; b2.A = 2'd2;
    step();
    checks++;
    if (b2.D !== 4'b0100 || b2.valid !== 1'b1 || b2.idx !== 2'd2) begin
      errors++;
      $display("FAIL direct_a2: D=%b valid=%b idx=%0d, required 0100/1/2", b2.D, b2.valid, b2.idx);
    end
    b2.A = 2'd0;
    step();
    checks++;
    if (b2.D !== 4'b0001 || b2.idx !== 2'd0) begin
      errors++;
      $display("FAIL direct_a0: D=%b idx=%0d, required 0001/0", b2.D, b2.idx);
    end
    b2.A = 2'd3; b2.load = 1'b1;
    step();
    checks++;
    if (b2.D !== 4'b1000 || b2.idx !== 2'd3 || b2.wrap !== 1'b0) begin
      errors++;
      $display("FAIL direct_a3_load: D=%b idx=%0d wrap=%b, required 1000/3/0", b2.D, b2.idx, b2.wrap);
    end
    b2.load = 1'b0;
  endtask

  task automatic test_scan_dwell1();
    logic [1:0] exp_idx [4] = '{2'd2, 2'd3, 2'd0, 2'd1};
    logic [3:0] exp_d;
    b2.mode = 1'b1; b2.A = 2'd1;
    step();
    checks++;
    if (b2.idx !== 2'd1 || b2.D !== 4'b0010 || b2.wrap !== 1'b0 || b2.valid !== 1'b1) begin
      errors++;
      $display("FAIL scan1_entry: idx=%0d D=%b wrap=%b valid=%b, required 1/0010/0/1",
               b2.idx, b2.D, b2.wrap, b2.valid);
    end
    b2.A = 2'd3;
    for (int i = 0; i < 4; i++) begin
      step();
      exp_d = 4'b0001 << exp_idx[i];
      checks++;
      if (b2.idx !== exp_idx[i] || b2.D !== exp_d || b2.wrap !== (exp_idx[i] == 2'd0)) begin
        errors++;
        $display("FAIL scan1_step%0d: idx=%0d D=%b wrap=%b, required %0d/%b/%b",
                 i, b2.idx, b2.D, b2.wrap, exp_idx[i], exp_d, exp_idx[i] == 2'd0);
      end
    end
  endtask

  task automatic test_load_on_wrap();
    step();
    step();
    checks++;
    if (b2.idx !== 2'd3) begin
      errors++;
      $display("FAIL load_pre: idx=%0d, required 3", b2.idx);
    end
    b2.load = 1'b1; b2.A = 2'd1;
    step();
    checks++;
    if (b2.idx !== 2'd1 || b2.wrap !== 1'b0 || b2.D !== 4'b0010) begin
      errors++;
      $display("FAIL load_on_wrap: idx=%0d wrap=%b D=%b, required 1/0/0010", b2.idx, b2.wrap, b2.D);
    end
    b2.load = 1'b0;
    step();
    checks++;
    if (b2.idx !== 2'd2) begin
      errors++;
      $display("FAIL load_resume: idx=%0d, required 2", b2.idx);
    end
  endtask

  task automatic test_scan_dwell3();
    logic [2:0] exp_idx [9] = '{3'd6, 3'd6, 3'd6, 3'd7, 3'd7, 3'd7, 3'd0, 3'd0, 3'd0};
    logic       exp_wrap [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [7:0] exp_d;
    b3.en = 1'b1; b3.mode = 1'b1; b3.A = 3'd6;
    for (int i = 0; i < 9; i++) begin
      step();
      if (i == 0) b3.A = 3'd1;
      exp_d = 8'h01 << exp_idx[i];
      checks++;
      if (b3.idx !== exp_idx[i] || b3.wrap !== exp_wrap[i] || b3.D !== exp_d) begin
        errors++;
        $display("FAIL scan3_cyc%0d: idx=%0d wrap=%b D=%b, required %0d/%b/%b",
                 i, b3.idx, b3.wrap, b3.D, exp_idx[i], exp_wrap[i], exp_d);
      end
    end
    b3.mode = 1'b0; b3.A = 3'd5;
    step();
    checks++;
    if (b3.D !== 8'b0010_0000 || b3.idx !== 3'd5) begin
      errors++;
      $display("FAIL scan3_to_direct: D=%b idx=%0d, required 00100000/5", b3.D, b3.idx);
    end
    b3.mode = 1'b1; b3.A = 3'd2;
    step();
    step();
    step();
    checks++;
    if (b3.idx !== 3'd2) begin
      errors++;
      $display("FAIL scan3_reentry_hold: idx=%0d, required 2", b3.idx);
    end
    step();
    checks++;
    if (b3.idx !== 3'd3 || b3.D !== 8'b0000_1000) begin
      errors++;
      $display("FAIL scan3_reentry_step: idx=%0d D=%b, required 3/00001000", b3.idx, b3.D);
    end
  endtask

  task automatic test_active_low();
    bl.en = 1'b0;
    step();
    checks++;
    if (bl.D !== 4'b1111 || bl.valid !== 1'b0) begin
      errors++;
      $display("FAIL al_idle: D=%b valid=%b, required 1111/0", bl.D, bl.valid);
    end
    bl.en = 1'b1; bl.mode = 1'b0; bl.A = 2'd3;
    step();
    checks++;
    if (bl.D !== 4'b0111 || bl.valid !== 1'b1 || bl.idx !== 2'd3) begin
      errors++;
      $display("FAIL al_direct: D=%b valid=%b idx=%0d, required 0111/1/3", bl.D, bl.valid, bl.idx);
    end
    bl.en = 1'b0;
    step();
    checks++;
    if (bl.D !== 4'b1111 || bl.valid !== 1'b0 || bl.idx !== 2'd3) begin
      errors++;
      $display("FAIL al_idle_hold: D=%b valid=%b idx=%0d, required 1111/0/3", bl.D, bl.valid, bl.idx);
    end
  endtask

  task automatic test_reset_mid_scan();
    b2.en = 1'b1; b2.mode = 1'b1; b2.A = 2'd2;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (b2.D !== 4'b0000 || b2.valid !== 1'b0 || b2.idx !== 2'd0 || b2.wrap !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_scan: D=%b valid=%b idx=%0d wrap=%b, required 0000/0/0/0",
               b2.D, b2.valid, b2.idx, b2.wrap);
    end
    b2.en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (b2.D !== 4'b0000 || b2.valid !== 1'b0 || b2.idx !== 2'd0) begin
        errors++;
        $display("FAIL rst_idle%0d: D=%b valid=%b idx=%0d, required 0000/0/0",
                 i, b2.D, b2.valid, b2.idx);
      end
    end
    b2.en = 1'b1; b2.A = 2'd2;
    step();
    checks++;
    if (b2.idx !== 2'd2 || b2.D !== 4'b0100 || b2.valid !== 1'b1) begin
      errors++;
      $display("FAIL rst_restart: idx=%0d D=%b valid=%b, required 2/0100/1", b2.idx, b2.D, b2.valid);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_direct();
    test_scan_dwell1();
    test_load_on_wrap();
    test_scan_dwell3();
    test_active_low();
    test_reset_mid_scan();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_decoder_scan
